// File: rtl/serial_frame_rx_pkg.sv
// Shared nextasic definitions for the serial frame receiver: FSM state encoding,
// default frame geometry and the synchroniser reset level for an idle-high line.
package serial_frame_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

  localparam int DEF_W   = 8;
  localparam int DEF_DIV = 16;

  localparam logic SYNC_RST_VAL = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Word handoff between the frame receiver (master) and the downstream
// clock-domain data synchroniser (slave).
interface serial_frame_rx_if
  import serial_frame_rx_pkg::*;
#(
  parameter int W = DEF_W
) ();

  logic [W-1:0] out_data;
  logic         out_data_valid;
  logic         out_ready;

  modport master (
    output out_data,
    output out_data_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_data_valid,
    output out_ready
  );

endinterface

// File: rtl/serial_frame_rx_sync.sv
// FF2SyncP: two-flop synchroniser for a single asynchronous bit with a
// parameterised reset level.
module FF2SyncP
  import serial_frame_rx_pkg::*;
#(
  parameter logic RST_VAL = SYNC_RST_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// NeXT-link frame receiver: idle-high line, start bit, W data bits MSB first,
// stop bit; good words are held in a register until the consumer accepts them.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int DIV = DEF_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   si,
  serial_frame_rx_if.master      word,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(W + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [W-1:0]     shift;
  logic             si_s;
  logic             si_d;
  logic             stop_ok_p1;
  logic             tick;
  logic             fall;

  FF2SyncP #(
    .RST_VAL (SYNC_RST_VAL)
  ) u_si_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (si),
    .q     (si_s)
  );

  assign tick = (cnt == '0);
  assign fall = si_d & ~si_s;
  assign busy = (state != IDLE);

  // Stage p0: bit-cell timing and frame FSM, all decisions on the synchronised line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      si_d       <= 1'b1;
      frame_err  <= 1'b0;
      stop_ok_p1 <= 1'b0;
    end else begin
      si_d       <= si_s;
      frame_err  <= 1'b0;
      stop_ok_p1 <= 1'b0;
      if (!tick) begin
        cnt <= cnt - 1'b1;
      end
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (tick) begin
            if (!si_s) begin
              state   <= DATA;
              cnt     <= CNT_FULL;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            bit_idx <= bit_idx + 1'b1;
            cnt     <= CNT_FULL;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            if (si_s) begin
              stop_ok_p1 <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The shift register is pure data and only meaningful once a full frame is in
  always_ff @(posedge clk) begin
    if (state == DATA && tick) begin
      shift <= (shift << 1) | W'(si_s);
    end
  end

  // Stage p1: hold-until-accepted output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word.out_data       <= '0;
      word.out_data_valid <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (stop_ok_p1) begin
        if (!word.out_data_valid || word.out_ready) begin
          word.out_data       <= shift;
          word.out_data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word.out_data_valid && word.out_ready) begin
        word.out_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with W=8, DIV=16.
module tb_serial_frame_rx;
  import serial_frame_rx_pkg::*;

  localparam int W   = 8;
  localparam int DIV = 16;
  localparam int LAT = 2 + 1 + DIV / 2 + (W + 1) * DIV + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic si = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  serial_frame_rx_if #(.W(W)) word ();

  serial_frame_rx #(
    .W   (W),
    .DIV (DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .si        (si),
    .word      (word),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int rise_n = 0;
  int hi_n = 0;
  int lo_n = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  int pulse_off = -1;
  int pulse_cyc = -1;
  logic busy_seen = 1'b0;
  logic vprev = 1'b0;
  logic [W-1:0] rise_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rise_n = 0; hi_n = 0; lo_n = 0; ferr_n = 0; ovr_n = 0; rise_cyc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (frame_err) ferr_n++;
    if (overrun) ovr_n++;
    if (word.out_data_valid) hi_n++; else lo_n++;
    if (busy) busy_seen = 1'b1;
    if (word.out_data_valid && !vprev) begin
      rise_n++;
      rise_cyc = cyc;
      rise_data = word.out_data;
    end
    vprev = word.out_data_valid;
    if (pulse_cyc >= 0) begin
      if (cyc == pulse_cyc) word.out_ready = 1'b1;
      else if (cyc == pulse_cyc + 1) word.out_ready = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic stop);
    si = 1'b0;
    fall_cyc = cyc;
    pulse_cyc = (pulse_off >= 0) ? fall_cyc + pulse_off : -1;
    repeat (DIV) step();
    for (int i = W - 1; i >= 0; i--) begin
      si = data[i];
      repeat (DIV) step();
    end
    si = stop;
    repeat (DIV) step();
    pulse_cyc = -1;
  endtask

  initial begin
    word.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_data", 32'(word.out_data), 32'h0);
    chk("rst_valid", 32'(word.out_data_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (4) step();

    // 1: single frame, consumer always ready
    clr();
    send_frame(8'hA5, 1'b1);
    repeat (4) step();
    chk("t1_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
    chk("t1_data", 32'(rise_data), 32'hA5);
    chk("t1_valid_cycles", 32'(hi_n), 32'd1);
    chk("t1_ferr", 32'(ferr_n), 32'd0);
    chk("t1_ovr", 32'(ovr_n), 32'd0);

    // 2: back-to-back with consumer stalled
    word.out_ready = 1'b0;
    clr();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    chk("t2_ovr", 32'(ovr_n), 32'd1);
    chk("t2_data", 32'(word.out_data), 32'h3C);
    chk("t2_valid", 32'(word.out_data_valid), 32'h1);
    chk("t2_rises", 32'(rise_n), 32'd1);
    word.out_ready = 1'b1;
    step();
    chk("t2_cleared", 32'(word.out_data_valid), 32'h0);
    repeat (6) step();
    chk("t2_no_stale", 32'(word.out_data), 32'h3C);
    chk("t2_rises_after", 32'(rise_n), 32'd1);

    // 3: bad stop bit, then line stuck low, then a good frame
    clr();
    send_frame(8'h81, 1'b0);
    chk("t3_ferr", 32'(ferr_n), 32'd1);
    chk("t3_no_valid", 32'(rise_n), 32'd0);
    chk("t3_ovr", 32'(ovr_n), 32'd0);
    busy_seen = 1'b0;
    repeat (48) step();
    chk("t3_low_busy", 32'(busy_seen), 32'h0);
    si = 1'b1;
    repeat (8) step();
    clr();
    send_frame(8'h42, 1'b1);
    chk("t3_next_data", 32'(rise_data), 32'h42);
    chk("t3_next_rises", 32'(rise_n), 32'd1);

    // 4: short glitch on an idle line
    clr();
    busy_seen = 1'b0;
    si = 1'b0;
    repeat (4) step();
    si = 1'b1;
    repeat (30) step();
    chk("t4_busy_seen", 32'(busy_seen), 32'h1);
    chk("t4_busy_end", 32'(busy), 32'h0);
    chk("t4_no_valid", 32'(rise_n), 32'd0);
    chk("t4_ferr", 32'(ferr_n), 32'd0);
    chk("t4_ovr", 32'(ovr_n), 32'd0);

    // 5: asynchronous reset in the middle of a frame
    word.out_ready = 1'b0;
    clr();
    send_frame(8'h5A, 1'b1);
    chk("t5_held_data", 32'(word.out_data), 32'h5A);
    si = 1'b0;
    repeat (DIV) step();
    si = 1'b1;
    repeat (DIV * 4 + DIV / 2) step();
    chk("t5_busy_before", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_valid", 32'(word.out_data_valid), 32'h0);
    chk("t5_rst_data", 32'(word.out_data), 32'h0);
    chk("t5_rst_flags", 32'({frame_err, overrun}), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    word.out_ready = 1'b1;
    clr();
    send_frame(8'h11, 1'b1);
    chk("t5_after_data", 32'(rise_data), 32'h11);
    chk("t5_after_rises", 32'(rise_n), 32'd1);

    // 6: consumer accepts on the very cycle a new word lands
    word.out_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    clr();
    pulse_off = LAT - 1;
    send_frame(8'h77, 1'b1);
    pulse_off = -1;
    chk("t6_data", 32'(word.out_data), 32'h77);
    chk("t6_valid", 32'(word.out_data_valid), 32'h1);
    chk("t6_valid_gap", 32'(lo_n), 32'd0);
    chk("t6_ovr", 32'(ovr_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
